// File: rtl/ascon_ctrl_fsm.sv
// ascon_ctrl_fsm: control sequencer for the ASCON-128 permutation datapath.
// Runs a full AEAD pass: init (pa=12), one AD block (pb=6), NB_BLOCKS
// plaintext blocks, and finalisation (pa=12 with key XORs). The last
// plaintext block is absorbed in the first round of finalisation.
module ascon_ctrl_fsm #(
    parameter int NB_BLOCKS = 4
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       start_i,
    input  logic       data_valid_i,
    output logic       data_sel_o,
    output logic       en_reg_state_o,
    output logic       en_xor_data_o,
    output logic       en_xor_key_o,
    output logic       en_xor_lsb_o,
    output logic       en_xor_key_end_o,
    output logic [3:0] round_o,
    output logic       en_cipher_o,
    output logic       en_tag_o,
    output logic       data_req_o,
    output logic       busy_o,
    output logic       done_o
);

    localparam int BLK_W = $clog2(NB_BLOCKS + 1);
    localparam logic [BLK_W-1:0] LAST_BLOCK = BLK_W'(NB_BLOCKS - 1);
    localparam logic [3:0] RND_PA   = 4'd0;   // first round of a 12-round phase
    localparam logic [3:0] RND_PB   = 4'd6;   // first round of a 6-round phase
    localparam logic [3:0] RND_LAST = 4'd11;  // every phase ends on round 11

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_AD_WAIT,
        S_AD,
        S_PT_WAIT,
        S_PT,
        S_FIN,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       round_q, round_d;
    logic [BLK_W-1:0] block_q, block_d;
    logic             last_round;

    assign last_round = (round_q == RND_LAST);

    // State, round and block registers; reset drops any message in flight.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of block order.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            round_q <= '0;
            block_q <= '0;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            block_q <= block_d;
        end
    end

    // Next-state logic; the round counter is held at 0 outside round phases.
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        round_d = round_q;
        block_d = block_q;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    round_d = RND_PA;
                    block_d = '0;
                end
            end
            S_INIT: begin
                if (last_round) begin
                    state_d = S_AD_WAIT;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_AD_WAIT: begin
                if (data_valid_i) begin
                    state_d = S_AD;
                    round_d = RND_PB;
                end
            end
            S_AD: begin
                if (last_round) begin
                    state_d = S_PT_WAIT;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_PT_WAIT: begin
                // Block counter never passes LAST_BLOCK, so != means "more to do".
                if (data_valid_i) begin
                    if (block_q != LAST_BLOCK) begin
                        state_d = S_PT;
                        round_d = RND_PB;
                    end else begin
                        state_d = S_FIN;
                        round_d = RND_PA;
                    end
                end
            end
            S_PT: begin
                if (last_round) begin
                    state_d = S_PT_WAIT;
                    round_d = '0;
                    block_d = block_q + 1'b1;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_FIN: begin
                if (last_round) begin
                    state_d = S_DONE;
                    round_d = '0;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    state_d = S_INIT;
                    round_d = RND_PA;
                    block_d = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                round_d = '0;
                block_d = '0;
            end
        endcase
    end

    // Moore output decode from state and round counter.
    always_comb begin
        data_sel_o       = 1'b0;
        en_reg_state_o   = 1'b0;
        en_xor_data_o    = 1'b0;
        en_xor_key_o     = 1'b0;
        en_xor_lsb_o     = 1'b0;
        en_xor_key_end_o = 1'b0;
        en_cipher_o      = 1'b0;
        en_tag_o         = 1'b0;
        data_req_o       = 1'b0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        round_o          = round_q;
        unique case (state_q)
            S_INIT: begin
                busy_o           = 1'b1;
                en_reg_state_o   = 1'b1;
                data_sel_o       = (round_q != RND_PA);  // round 0 takes fresh state_i
                en_xor_key_end_o = last_round;
            end
            S_AD: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (round_q == RND_PB);
                en_xor_lsb_o   = last_round;             // domain separation after AD
            end
            S_PT: begin
                busy_o         = 1'b1;
                en_reg_state_o = 1'b1;
                data_sel_o     = 1'b1;
                en_xor_data_o  = (round_q == RND_PB);
                en_cipher_o    = (round_q == RND_PB);
            end
            S_FIN: begin
                busy_o           = 1'b1;
                en_reg_state_o   = 1'b1;
                data_sel_o       = 1'b1;
                en_xor_data_o    = (round_q == RND_PA);  // last block absorbed here
                en_cipher_o      = (round_q == RND_PA);
                en_xor_key_o     = (round_q == RND_PA);
                en_xor_key_end_o = last_round;
                en_tag_o         = last_round;
            end
            S_AD_WAIT, S_PT_WAIT: begin
                busy_o     = 1'b1;
                data_req_o = 1'b1;
                round_o    = '0;
            end
            S_DONE: begin
                done_o  = 1'b1;
                round_o = '0;
            end
            default: begin
                round_o = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed testbench for ascon_ctrl_fsm: one instance with NB_BLOCKS=4 and
// one with NB_BLOCKS=1 share clock and reset. Cycle 1 is the first INIT
// cycle after the edge that samples start_i.
module tb_ascon_ctrl_fsm;

    typedef struct packed {
        logic       data_sel;
        logic       en_reg_state;
        logic       en_xor_data;
        logic       en_xor_key;
        logic       en_xor_lsb;
        logic       en_xor_key_end;
        logic [3:0] round;
        logic       en_cipher;
        logic       en_tag;
        logic       data_req;
        logic       busy;
        logic       done;
    } ctrl_t;

    logic clk = 1'b0;
    logic rst;
    logic start4, valid4, start1, valid1;

    logic       a_sel, a_reg, a_xd, a_xk, a_lsb, a_xke, a_ci, a_tag, a_req, a_busy, a_done;
    logic [3:0] a_rnd;
    logic       b_sel, b_reg, b_xd, b_xk, b_lsb, b_xke, b_ci, b_tag, b_req, b_busy, b_done;
    logic [3:0] b_rnd;

    ctrl_t o4, o1;
    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    ascon_ctrl_fsm #(.NB_BLOCKS(4)) dut4 (
        .clock_i(clk), .reset_i(rst), .start_i(start4), .data_valid_i(valid4),
        .data_sel_o(a_sel), .en_reg_state_o(a_reg), .en_xor_data_o(a_xd),
        .en_xor_key_o(a_xk), .en_xor_lsb_o(a_lsb), .en_xor_key_end_o(a_xke),
        .round_o(a_rnd), .en_cipher_o(a_ci), .en_tag_o(a_tag),
        .data_req_o(a_req), .busy_o(a_busy), .done_o(a_done)
    );

    ascon_ctrl_fsm #(.NB_BLOCKS(1)) dut1 (
        .clock_i(clk), .reset_i(rst), .start_i(start1), .data_valid_i(valid1),
        .data_sel_o(b_sel), .en_reg_state_o(b_reg), .en_xor_data_o(b_xd),
        .en_xor_key_o(b_xk), .en_xor_lsb_o(b_lsb), .en_xor_key_end_o(b_xke),
        .round_o(b_rnd), .en_cipher_o(b_ci), .en_tag_o(b_tag),
        .data_req_o(b_req), .busy_o(b_busy), .done_o(b_done)
    );

    assign o4 = {a_sel, a_reg, a_xd, a_xk, a_lsb, a_xke, a_rnd, a_ci, a_tag, a_req, a_busy, a_done};
    assign o1 = {b_sel, b_reg, b_xd, b_xk, b_lsb, b_xke, b_rnd, b_ci, b_tag, b_req, b_busy, b_done};

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one clock; outputs are read 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic ctrl_t obs(input bit sel);
        return sel ? o1 : o4;
    endfunction

    task automatic set_start(input bit sel, input logic v);
        if (sel) start1 = v; else start4 = v;
    endtask

    task automatic set_valid(input bit sel, input logic v);
        if (sel) valid1 = v; else valid4 = v;
    endtask

    // Runs one message from IDLE/DONE, holding data_valid_i low for
    // stall_len cycles starting at stall_from, optionally pulsing start_i
    // at cycle pulse_at, then checks the recorded event schedule.
    task automatic run_message(input bit sel, input string name,
                               input int stall_from, input int stall_len, input int pulse_at,
                               input int exp_done, input int exp_ci_cnt, input int exp_ci_last,
                               input int exp_tag, input int exp_xd_cnt, input int exp_xke_cnt,
                               input int exp_lsb, input int exp_xk);
        ctrl_t o;
        int cyc = 1;
        int ci_cnt = 0, ci_last = 0, tag_cnt = 0, tag_cyc = 0;
        int xd_cnt = 0, xke_cnt = 0, lsb_cyc = 0, xk_cyc = 0;
        bit in_stall;
        set_start(sel, 1'b1);
        set_valid(sel, 1'b1);
        step();
        set_start(sel, 1'b0);
        o = obs(sel);
        while (!o.done && cyc < 200) begin
            in_stall = (cyc >= stall_from) && (cyc < stall_from + stall_len);
            set_valid(sel, !in_stall);
            set_start(sel, cyc == pulse_at);
            if (in_stall) begin
                check({name, "_stall_req"}, o.data_req, 1);
                check({name, "_stall_reg"}, o.en_reg_state, 0);
            end
            if (o.en_cipher) begin ci_cnt++; ci_last = cyc; end
            if (o.en_tag) begin tag_cnt++; tag_cyc = cyc; end
            if (o.en_xor_data) xd_cnt++;
            if (o.en_xor_key_end) xke_cnt++;
            if (o.en_xor_lsb) lsb_cyc = cyc;
            if (o.en_xor_key) xk_cyc = cyc;
            step();
            cyc++;
            o = obs(sel);
        end
        set_start(sel, 1'b0);
        set_valid(sel, 1'b0);
        check({name, "_done_cycle"}, cyc, exp_done);
        check({name, "_cipher_cnt"}, ci_cnt, exp_ci_cnt);
        check({name, "_cipher_last"}, ci_last, exp_ci_last);
        check({name, "_tag_cnt"}, tag_cnt, 1);
        check({name, "_tag_cycle"}, tag_cyc, exp_tag);
        check({name, "_xor_data_cnt"}, xd_cnt, exp_xd_cnt);
        check({name, "_key_end_cnt"}, xke_cnt, exp_xke_cnt);
        check({name, "_lsb_cycle"}, lsb_cyc, exp_lsb);
        check({name, "_xor_key_cycle"}, xk_cyc, exp_xk);
    endtask

    ctrl_t init_r0;

    initial begin
        rst = 1'b1; start4 = 1'b0; valid4 = 1'b0; start1 = 1'b0; valid1 = 1'b0;
        init_r0 = '0;
        init_r0.en_reg_state = 1'b1;
        init_r0.busy = 1'b1;

        // Reset state of both instances
        step(); step();
        check("reset_outputs_nb4", o4, 0);
        check("reset_outputs_nb1", o1, 0);
        rst = 1'b0;
        step();
        check("idle_hold", o4, 0);

        // Reset asserted in INIT round 5
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        repeat (5) step();
        check("mid_init_round", o4.round, 5);
        rst = 1'b1;
        step();
        check("mid_init_reset", o4, 0);
        rst = 1'b0;
        step();

        // INIT sequence with data_valid_i low so it parks in AD_WAIT
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("init_r0_vector", o4, init_r0);
        for (int r = 0; r < 12; r++) begin
            check($sformatf("init_round_%0d", r), o4.round, r);
            check($sformatf("init_sel_%0d", r), o4.data_sel, (r != 0));
            check($sformatf("init_key_end_%0d", r), o4.en_xor_key_end, (r == 11));
            check($sformatf("init_reg_%0d", r), o4.en_reg_state, 1);
            step();
        end
        for (int i = 0; i < 3; i++) begin
            check("ad_wait_req", o4.data_req, 1);
            check("ad_wait_reg", o4.en_reg_state, 0);
            check("ad_wait_round", o4.round, 0);
            check("ad_wait_busy", o4.busy, 1);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Full message, NB_BLOCKS=4, start_i pulsed while busy at cycle 30
        run_message(0, "full4", 0, 0, 30, 54, 4, 42, 53, 5, 2, 19, 42);
        check("done_level", o4.done, 1);
        check("done_busy", o4.busy, 0);
        repeat (3) step();
        check("done_hold", o4.done, 1);
        check("done_reg", o4.en_reg_state, 0);

        // Restart from DONE goes straight to INIT round 0
        start4 = 1'b1;
        step();
        start4 = 1'b0;
        check("restart_init_r0", o4, init_r0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();

        // Five-cycle stall in the first PT_WAIT (cycle 20)
        run_message(0, "stall4", 20, 5, -1, 59, 4, 47, 58, 5, 2, 19, 47);

        // NB_BLOCKS=1: no PT phase, single cipher strobe in FIN round 0
        run_message(1, "nb1", 0, 0, -1, 33, 1, 21, 32, 2, 2, 19, 21);
        check("nb1_done", o1.done, 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
